// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter and
// dump sequencer.
package regfile_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } state_e;

  // Requester indices into the request/grant vectors.
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LD  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The tie-break pointer moves away from the
// winner only when a grant is actually accepted.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic prio_q;  // requester index that wins the next tie

  // NOTE: every output of a combinational block gets a default first so that no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    gnt = '0;
    if (enable) begin
      if (req[REQ_ALU] && (!req[REQ_LD] || prio_q == REQ_ALU)) begin
        gnt[REQ_ALU] = 1'b1;
      end else if (req[REQ_LD]) begin
        gnt[REQ_LD] = 1'b1;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= REQ_ALU;
    end else if (accept) begin
      prio_q <= gnt[REQ_ALU] ? REQ_LD : REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Owns the register file's write port (round-robin between ALU and load
// writeback) and its inspection port (sequenced snapshot dump of all registers).
module regfile_access_ctrl #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_wr_valid,
  output logic              alu_wr_ready,
  input  logic [ADDR_W-1:0] alu_wr_addr,
  input  logic [DATA_W-1:0] alu_wr_data,
  input  logic              ld_wr_valid,
  output logic              ld_wr_ready,
  input  logic [ADDR_W-1:0] ld_wr_addr,
  input  logic [DATA_W-1:0] ld_wr_data,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [ADDR_W-1:0] rf_inr,
  input  logic [DATA_W-1:0] rf_out_value
);

  import regfile_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dump_idx_q;
  logic              wr_enable;
  logic              xfer;
  logic [1:0]        req, gnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Writes are frozen from the dump_start cycle onward so the snapshot is coherent.
  assign wr_enable = !rst && (state_q == ST_IDLE) && !dump_start;

  always_comb begin
    req          = '0;
    req[REQ_ALU] = alu_wr_valid;
    req[REQ_LD]  = ld_wr_valid;
  end

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .enable (wr_enable),
    .accept (xfer),
    .gnt    (gnt)
  );

  assign alu_wr_ready = gnt[REQ_ALU];
  assign ld_wr_ready  = gnt[REQ_LD];
  assign xfer         = |gnt;
  assign wr_addr      = gnt[REQ_LD] ? ld_wr_addr : alu_wr_addr;
  assign wr_data      = gnt[REQ_LD] ? ld_wr_data : alu_wr_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dump_start) state_d = ST_DUMP;
      ST_DUMP: if (dump_idx_q == ADDR_W'(NUM_REGS - 1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dump_busy = (state_q == ST_DUMP);
  assign rf_inr    = dump_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      dump_idx_q    <= '0;
      rf_reg_write  <= 1'b0;
      rf_rd         <= '0;
      rf_write_data <= '0;
      dump_valid    <= 1'b0;
      dump_addr     <= '0;
      dump_data     <= '0;
    end else begin
      state_q <= state_d;

      // r0 is hardwired: the handshake completes but the write strobe stays low.
      rf_reg_write <= xfer && (wr_addr != '0);
      if (xfer) begin
        rf_rd         <= wr_addr;
        rf_write_data <= wr_data;
      end

      dump_valid <= (state_q == ST_DUMP);
      if (state_q == ST_DUMP) begin
        dump_addr <= dump_idx_q;
        dump_data <= rf_out_value;
      end
      dump_idx_q <= (state_d == ST_DUMP && state_q == ST_DUMP) ? dump_idx_q + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: directed scenarios plus a random
// run compared cycle by cycle against a transaction-level reference model.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_wr_valid = 1'b0, alu_wr_ready;
  logic [3:0]  alu_wr_addr = '0;
  logic [15:0] alu_wr_data = '0;
  logic        ld_wr_valid = 1'b0, ld_wr_ready;
  logic [3:0]  ld_wr_addr = '0;
  logic [15:0] ld_wr_data = '0;
  logic        dump_start = 1'b0, dump_busy, dump_valid;
  logic [3:0]  dump_addr;
  logic [15:0] dump_data;
  logic        rf_reg_write;
  logic [3:0]  rf_rd, rf_inr;
  logic [15:0] rf_write_data, rf_out_value;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  regfile_access_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .alu_wr_valid  (alu_wr_valid),
    .alu_wr_ready  (alu_wr_ready),
    .alu_wr_addr   (alu_wr_addr),
    .alu_wr_data   (alu_wr_data),
    .ld_wr_valid   (ld_wr_valid),
    .ld_wr_ready   (ld_wr_ready),
    .ld_wr_addr    (ld_wr_addr),
    .ld_wr_data    (ld_wr_data),
    .dump_start    (dump_start),
    .dump_busy     (dump_busy),
    .dump_valid    (dump_valid),
    .dump_addr     (dump_addr),
    .dump_data     (dump_data),
    .rf_reg_write  (rf_reg_write),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .rf_inr        (rf_inr),
    .rf_out_value  (rf_out_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file driven by the block; accepts any address so a stray r0 write shows.
  logic [15:0] rf_mem [16] = '{default: '0};
  always @(posedge clk) if (rf_reg_write) rf_mem[rf_rd] <= rf_write_data;
  assign rf_out_value = rf_mem[rf_inr];

  // Reference model: who wins, what each register holds, where the dump is.
  logic        m_prio_ld = 1'b0;
  int          m_dump_k  = -1;
  logic [15:0] m_rf [16] = '{default: '0};
  logic        e_wr = 1'b0, e_dv = 1'b0;
  logic [3:0]  e_rd = '0, e_da = '0, e_inr;
  logic [15:0] e_wdata = '0, e_dd = '0;
  logic        e_alu_rdy, e_ld_rdy;

  always_comb begin
    e_alu_rdy = 1'b0;
    e_ld_rdy  = 1'b0;
    if (rst !== 1'b1 && m_dump_k < 0 && dump_start !== 1'b1) begin
      if (alu_wr_valid && ld_wr_valid) begin
        if (m_prio_ld) e_ld_rdy = 1'b1;
        else           e_alu_rdy = 1'b1;
      end else if (alu_wr_valid) begin
        e_alu_rdy = 1'b1;
      end else if (ld_wr_valid) begin
        e_ld_rdy = 1'b1;
      end
    end
  end

  always_comb begin
    e_inr = '0;
    if (m_dump_k >= 0) e_inr = m_dump_k[3:0];
  end

  always @(posedge clk) begin
    if (rst) begin
      m_prio_ld <= 1'b0;
      m_dump_k  <= -1;
      e_wr <= 1'b0; e_rd <= '0; e_wdata <= '0;
      e_dv <= 1'b0; e_da <= '0; e_dd <= '0;
    end else begin
      e_wr <= 1'b0;
      e_dv <= 1'b0;
      if (e_alu_rdy) begin
        e_wr <= (alu_wr_addr != 0); e_rd <= alu_wr_addr; e_wdata <= alu_wr_data;
        if (alu_wr_addr != 0) m_rf[alu_wr_addr] <= alu_wr_data;
        m_prio_ld <= 1'b1;
      end else if (e_ld_rdy) begin
        e_wr <= (ld_wr_addr != 0); e_rd <= ld_wr_addr; e_wdata <= ld_wr_data;
        if (ld_wr_addr != 0) m_rf[ld_wr_addr] <= ld_wr_data;
        m_prio_ld <= 1'b0;
      end
      if (m_dump_k >= 0) begin
        e_dv <= 1'b1;
        e_da <= m_dump_k[3:0];
        e_dd <= m_rf[m_dump_k];
        m_dump_k <= (m_dump_k == 15) ? -1 : m_dump_k + 1;
      end else if (dump_start) begin
        m_dump_k <= 0;
      end
    end
  end

  // Every dump beat, tagged with the cycle it was visible in.
  int bt_addr[$], bt_data[$], bt_cyc[$];
  always @(negedge clk) begin
    if (dump_valid === 1'b1) begin
      bt_addr.push_back(int'(dump_addr));
      bt_data.push_back(int'(dump_data));
      bt_cyc.push_back(cyc);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dump(output int s);
    dump_start = 1'b1;
    s = cyc;
    next_cycle();
    dump_start = 1'b0;
    repeat (18) next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_wr_valid = 1'b1;
      alu_wr_addr  = 4'(10 + i);
      alu_wr_data  = 16'($urandom);
      next_cycle();
    end
    ld_wr_valid = 1'b1; ld_wr_addr = 4'd2; ld_wr_data = 16'h0202;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({alu_wr_ready, ld_wr_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 00", {alu_wr_ready, ld_wr_ready});
    end
    next_cycle();
    rst = 1'b0; alu_wr_valid = 1'b0; ld_wr_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rf_reg_write, rf_rd, rf_write_data, rf_inr, dump_busy, dump_valid, dump_addr,
         dump_data, alu_wr_ready, ld_wr_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%b rd=%h wd=%h inr=%h busy=%b dv=%b da=%h dd=%h want all 0",
               rf_reg_write, rf_rd, rf_write_data, rf_inr, dump_busy, dump_valid, dump_addr, dump_data);
    end
    next_cycle();
    alu_wr_valid = 1'b1; alu_wr_addr = 4'd11; alu_wr_data = 16'h0b0b;
    ld_wr_valid  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({alu_wr_ready, ld_wr_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_first_grant: got alu/ld=%b want 10", {alu_wr_ready, ld_wr_ready});
    end
    next_cycle();
    alu_wr_valid = 1'b0;
    next_cycle();
    ld_wr_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_write();
    int s, b0;
    alu_wr_valid = 1'b1; alu_wr_addr = 4'd5; alu_wr_data = 16'h1234;
    @(negedge clk);
    n_cmp++;
    if (alu_wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_ready: got %b want 1", alu_wr_ready);
    end
    next_cycle();
    alu_wr_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rf_reg_write, rf_rd, rf_write_data} !== {1'b1, 4'd5, 16'h1234}) begin
      n_err++;
      $display("FAIL single_port: got we=%b rd=%h wd=%h want 1 5 1234", rf_reg_write, rf_rd, rf_write_data);
    end
    next_cycle();
    b0 = bt_addr.size();
    run_dump(s);
    n_cmp++;
    if (bt_addr.size() != b0 + 16) begin
      n_err++;
      $display("FAIL single_dump_len: got %0d beats want 16", bt_addr.size() - b0);
    end else if (bt_addr[b0+5] != 5 || bt_data[b0+5] != 'h1234) begin
      n_err++;
      $display("FAIL single_dump_r5: got addr %0d data %h want 5 1234", bt_addr[b0+5], bt_data[b0+5]);
    end
  endtask

  task automatic test_contention();
    logic [3:0]  a_ad [2] = '{4'd6, 4'd7};
    logic [15:0] a_d  [2] = '{16'hAAAA, 16'hA7A7};
    logic [3:0]  l_ad [2] = '{4'd6, 4'd8};
    logic [15:0] l_d  [2] = '{16'h5555, 16'h5858};
    logic [3:0]  w_ad [4] = '{4'd6, 4'd6, 4'd7, 4'd8};
    logic [15:0] w_d  [4] = '{16'hAAAA, 16'h5555, 16'hA7A7, 16'h5858};
    int ai = 0, li = 0;
    ld_wr_valid = 1'b1; ld_wr_addr = 4'd9; ld_wr_data = 16'h0909;
    next_cycle();
    ld_wr_valid = 1'b0;
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      alu_wr_valid = (ai < 2);
      alu_wr_addr  = a_ad[ai < 2 ? ai : 1];
      alu_wr_data  = a_d[ai < 2 ? ai : 1];
      ld_wr_valid  = (li < 2);
      ld_wr_addr   = l_ad[li < 2 ? li : 1];
      ld_wr_data   = l_d[li < 2 ? li : 1];
      @(negedge clk);
      if (c < 4) begin
        n_cmp++;
        if ({alu_wr_ready, ld_wr_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_err++;
          $display("FAIL contention_grant%0d: got alu/ld=%b want %b", c,
                   {alu_wr_ready, ld_wr_ready}, (c % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      if (c > 0) begin
        n_cmp++;
        if ({rf_reg_write, rf_rd, rf_write_data} !== {1'b1, w_ad[c-1], w_d[c-1]}) begin
          n_err++;
          $display("FAIL contention_port%0d: got we=%b rd=%h wd=%h want 1 %h %h", c,
                   rf_reg_write, rf_rd, rf_write_data, w_ad[c-1], w_d[c-1]);
        end
      end
      if (alu_wr_ready === 1'b1) ai++;
      if (ld_wr_ready === 1'b1) li++;
      next_cycle();
    end
    next_cycle();
    n_cmp++;
    if (rf_mem[6] !== 16'h5555 || rf_mem[7] !== 16'hA7A7 || rf_mem[8] !== 16'h5858) begin
      n_err++;
      $display("FAIL contention_final: got r6=%h r7=%h r8=%h want 5555 a7a7 5858", rf_mem[6], rf_mem[7], rf_mem[8]);
    end
  endtask

  task automatic test_r0();
    int s, b0;
    ld_wr_valid = 1'b1; ld_wr_addr = 4'd0; ld_wr_data = 16'hFFFF;
    @(negedge clk);
    n_cmp++;
    if (ld_wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL r0_ready: got %b want 1", ld_wr_ready);
    end
    next_cycle();
    ld_wr_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rf_reg_write !== 1'b0) begin
      n_err++;
      $display("FAIL r0_no_write: got %b want 0", rf_reg_write);
    end
    next_cycle();
    b0 = bt_addr.size();
    run_dump(s);
    n_cmp++;
    if (bt_addr.size() != b0 + 16) begin
      n_err++;
      $display("FAIL r0_dump_len: got %0d beats want 16", bt_addr.size() - b0);
    end else if (bt_addr[b0] != 0 || bt_data[b0] != 0) begin
      n_err++;
      $display("FAIL r0_dump: got addr %0d data %h want 0 0", bt_addr[b0], bt_data[b0]);
    end
  endtask

  task automatic test_dump_coherence();
    int s, b0, bad;
    for (int i = 1; i < 16; i++) begin
      alu_wr_valid = 1'b1; alu_wr_addr = 4'(i); alu_wr_data = 16'(i * 257);
      next_cycle();
    end
    b0 = bt_addr.size();
    s = cyc;
    alu_wr_valid = 1'b1; alu_wr_addr = 4'd3; alu_wr_data = 16'hBEEF;
    for (int c = 0; c <= 17; c++) begin
      dump_start = (c == 0 || c == 5);
      @(negedge clk);
      n_cmp++;
      if (alu_wr_ready !== (c == 17)) begin
        n_err++;
        $display("FAIL coh_ready_S+%0d: got %b want %b", c, alu_wr_ready, (c == 17));
      end
      n_cmp++;
      if (dump_busy !== (c >= 1 && c <= 16)) begin
        n_err++;
        $display("FAIL coh_busy_S+%0d: got %b want %b", c, dump_busy, (c >= 1 && c <= 16));
      end
      if (c >= 1 && c <= 16) begin
        n_cmp++;
        if (rf_inr !== 4'(c - 1)) begin
          n_err++;
          $display("FAIL coh_inr_S+%0d: got %0d want %0d", c, rf_inr, c - 1);
        end
      end
      next_cycle();
    end
    dump_start = 1'b0; alu_wr_valid = 1'b0;
    repeat (4) next_cycle();
    n_cmp++;
    if (bt_addr.size() != b0 + 16) begin
      n_err++;
      $display("FAIL coh_len: got %0d beats want 16", bt_addr.size() - b0);
    end else begin
      bad = 0;
      for (int k = 0; k < 16; k++) begin
        if (bt_addr[b0+k] != k || bt_data[b0+k] != k * 257 || bt_cyc[b0+k] != s + 2 + k) begin
          if (bad == 0)
            $display("FAIL coh_beat%0d: got addr %0d data %h cyc S+%0d want %0d %h S+%0d", k,
                     bt_addr[b0+k], bt_data[b0+k], bt_cyc[b0+k] - s, k, k * 257, k + 2);
          bad++;
        end
      end
      if (bad != 0) n_err++;
    end
    n_cmp++;
    if (rf_mem[3] !== 16'hBEEF) begin
      n_err++;
      $display("FAIL coh_late_write: got r3=%h want beef", rf_mem[3]);
    end
  endtask

  task automatic test_reset_mid_dump();
    int s, b0;
    b0 = bt_addr.size();
    dump_start = 1'b1;
    s = cyc;
    next_cycle();
    dump_start = 1'b0;
    repeat (7) next_cycle();
    rst = 1'b1;
    alu_wr_valid = 1'b1; alu_wr_addr = 4'd4; alu_wr_data = 16'h4444;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({dump_busy, dump_valid, alu_wr_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL midrst_state: got busy/dv/rdy=%b want 001", {dump_busy, dump_valid, alu_wr_ready});
    end
    next_cycle();
    alu_wr_valid = 1'b0;
    repeat (12) next_cycle();
    n_cmp++;
    if (bt_addr.size() != b0 + 7 || bt_cyc[bt_cyc.size()-1] > s + 8) begin
      n_err++;
      $display("FAIL midrst_beats: got %0d beats last at S+%0d want 7 ending S+8",
               bt_addr.size() - b0, bt_cyc[bt_cyc.size()-1] - s);
    end
    n_cmp++;
    if (rf_mem[4] !== 16'h4444) begin
      n_err++;
      $display("FAIL midrst_write: got r4=%h want 4444", rf_mem[4]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      alu_wr_valid = ($urandom_range(0, 3) != 0);
      alu_wr_addr  = 4'($urandom);
      alu_wr_data  = 16'($urandom);
      ld_wr_valid  = ($urandom_range(0, 3) != 0);
      ld_wr_addr   = 4'($urandom);
      ld_wr_data   = 16'($urandom);
      dump_start   = ($urandom_range(0, 40) == 0);
      rst          = ($urandom_range(0, 150) == 0);
      @(negedge clk);
      n_cmp++;
      if ({alu_wr_ready, ld_wr_ready} !== {e_alu_rdy, e_ld_rdy}) begin
        n_err++;
        $display("FAIL rand_ready@%0d: got %b want %b", cyc, {alu_wr_ready, ld_wr_ready}, {e_alu_rdy, e_ld_rdy});
      end
      n_cmp++;
      if ({rf_reg_write, rf_rd, rf_write_data} !== {e_wr, e_rd, e_wdata}) begin
        n_err++;
        $display("FAIL rand_port@%0d: got %b %h %h want %b %h %h", cyc,
                 rf_reg_write, rf_rd, rf_write_data, e_wr, e_rd, e_wdata);
      end
      n_cmp++;
      if ({dump_valid, dump_addr, dump_data} !== {e_dv, e_da, e_dd}) begin
        n_err++;
        $display("FAIL rand_dump@%0d: got %b %h %h want %b %h %h", cyc,
                 dump_valid, dump_addr, dump_data, e_dv, e_da, e_dd);
      end
      n_cmp++;
      if ({dump_busy, rf_inr} !== {(m_dump_k >= 0), e_inr}) begin
        n_err++;
        $display("FAIL rand_busy@%0d: got %b %h want %b %h", cyc, dump_busy, rf_inr, (m_dump_k >= 0), e_inr);
      end
      next_cycle();
    end
    rst = 1'b0; alu_wr_valid = 1'b0; ld_wr_valid = 1'b0; dump_start = 1'b0;
    next_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_r0();
    test_dump_coherence();
    test_reset_mid_dump();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Write-port arbiter and dump sequencer for the 16 x 16-bit register file. It shares the register file's single write port between two writeback requesters: the ALU result path and the load-data path. Each requester uses a valid/ready handshake, and the block grants them round-robin. It also sequences the register file's inspection read port (`inr`/`outValue`) to stream a coherent snapshot of all registers to a debug/display consumer. It sits between the writeback muxing and the register file, and owns the file's `RegWrite`, `rd`, `WriteData` and `inr` inputs.

## Interface
- `NUM_REGS`, 16: register count; must equal 2**`ADDR_W`
- `ADDR_W`, 4: register address width
- `DATA_W`, 16: register data width
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `alu_wr_valid`  in  1  ALU writeback request
- `alu_wr_ready`  out  1  ALU request accepted this cycle
- `alu_wr_addr`  in  `ADDR_W`  ALU destination register
- `alu_wr_data`  in  `DATA_W`  ALU write data
- `ld_wr_valid` / `ld_wr_ready` / `ld_wr_addr` / `ld_wr_data`: same as the four ALU ports, for load writeback
- `dump_start`  in  1  one-cycle pulse requesting a full register dump
- `dump_busy`  out  1  dump in progress
- `dump_valid`  out  1  `dump_addr`/`dump_data` carry one register this cycle
- `dump_addr`  out  `ADDR_W`  index of the dumped register
- `dump_data`  out  `DATA_W`  value of the dumped register
- `rf_reg_write`  out  1  drives the register file `RegWrite`
- `rf_rd`  out  `ADDR_W`  drives the register file `rd`
- `rf_write_data`  out  `DATA_W`  drives the register file `WriteData`
- `rf_inr`  out  `ADDR_W`  drives the register file `inr`
- `rf_out_value`  in  `DATA_W`  the register file's `outValue` (combinational read)

## Operation
- **States:** IDLE, DUMP.
- **Reset values:** state IDLE; round-robin pointer gives priority to ALU. All outputs are 0: `rf_reg_write`, `rf_rd`, `rf_write_data`, `rf_inr`, `dump_*`, `*_ready`.
- **Readiness:** `*_ready` is combinational and can be high only when state is IDLE and `dump_start` is 0.
  - One valid requester: it gets ready.
  - Both valid: the requester not granted last gets ready; the pointer then flips.
  - The pointer updates only on a completed transfer.
- **Transfer:** a transfer occurs when valid and ready are both high. On the next edge the block registers `rf_reg_write` = (addr != 0), `rf_rd` = addr and `rf_write_data` = data.
- **Idle write port:** with no transfer, `rf_reg_write` is registered to 0; `rf_rd` and `rf_write_data` hold their values.
- **Writes to r0:** the handshake completes but no write is issued.
- **Same-address requests in the same cycle:** they are serialized in grant order; the later grant's data persists.
- **Dump start:** `dump_start` is accepted only in IDLE. On acceptance the next state is DUMP with index 0. The pulse is ignored while busy.
- **DUMP, per cycle with index k:**
  - `rf_inr` = k.
  - On the edge, register `dump_valid`=1, `dump_addr`=k, `dump_data`=`rf_out_value`.
  - k increments; after k=15 the next state is IDLE.
- **Dump outputs between samples:** `dump_valid` is 1 only in the cycle after each sample; otherwise 0. `dump_addr` and `dump_data` hold their values.
- **`dump_busy`:** high exactly when state is DUMP.
- **Snapshot coherence:** writes are blocked from the `dump_start` cycle through the last DUMP cycle. A write granted in the cycle before `dump_start` is committed during the accept cycle, so it is visible in the dump.
- **Reset mid-dump:** return to IDLE immediately and drop the partial dump. No further `dump_valid` is asserted.

## Timing
- **Write latency:** handshake in cycle N; `rf_reg_write` high in cycle N+1; the register file captures at the end of N+1.
- **Throughput:** one write per cycle when not dumping; alternating A/L/A/L when both requesters stream.
- **Dump length:** `dump_start` in cycle S; `rf_inr`=0..15 in cycles S+1..S+16; `dump_valid` in cycles S+2..S+17.
- **Busy window:** `dump_busy` is high in S+1..S+16. Readies are 0 in S..S+16 and may be high again in S+17.
- **Reset:** takes effect at the first edge with `rst`=1.
- **Combinational paths:** none from `rf_out_value` to any output.

## Structure
- **Package `regfile_pkg`:** `ADDR_W`, `DATA_W`, `NUM_REGS`, the state enum (`ST_IDLE`, `ST_DUMP`), and the requester index constants (`REQ_ALU`=0, `REQ_LD`=1).
- **Sub-module `rr_arbiter2`:** two-request round-robin grant with a pointer that updates on an accept input. Instantiated once.
- **Top level:** FSM, write-port register stage, dump counter and output registers.

## Test plan
- **Reset:** assert `rst` mid-stream → every output is 0 on the next cycle; the first contested grant afterwards goes to ALU.
- **Single write:** ALU writes r5=0x1234 in cycle N → cycle N+1 shows `rf_reg_write`=1, `rf_rd`=5, `rf_write_data`=0x1234. A subsequent dump reports r5=0x1234.
- **Contention:** both requesters valid for 4 cycles (ALU→r6=0xAAAA, LD→r6=0x5555, then r7/r8) → grants alternate ALU, LD, ALU, LD with no cycle lost. The final r6 is 0x5555.
- **r0 write:** LD writes r0=0xFFFF → `ld_wr_ready`=1 and `rf_reg_write` stays 0. The dump reports r0=0.
- **Dump coherence:** preload r1..r15 = index*0x0101, then pulse `dump_start` while ALU is valid → exactly 16 `dump_valid` beats with addr 0..15 and matching data. `alu_wr_ready`=0 in S..S+16 and the ALU write completes in S+17. A second pulse in S+5 is ignored.
- **Reset mid-dump:** `rst` in S+8 → no `dump_valid` after S+8, `dump_busy`=0, and writes are accepted again.
